// File: rtl/proc_pkg.sv
// Shared widths, opcode and state encodings for the instruction controller.
package proc_pkg;

    localparam int PC_W    = 5;
    localparam int DATA_W  = 8;
    localparam int REG_AW  = 3;
    localparam int DMEM_AW = 6;
    localparam int INSTR_W = 12;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_CMP   = 3'b011,
        OP_BNZ   = 3'b100,
        OP_JMP   = 3'b101,
        OP_NOP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into register-file, data-memory and ALU controls.
module instr_decoder
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_rf_we,
    output logic               o_dmem_we,
    output logic               o_wb_sel,
    output logic               o_alu_select,
    output logic [REG_AW-1:0]  o_rf_wa,
    output logic [REG_AW-1:0]  o_rf_ra,
    output logic [REG_AW-1:0]  o_rf_rb,
    output logic               o_is_bnz,
    output logic               o_is_jmp,
    output logic               o_is_halt
);

    opcode_e             w_op;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_ra;
    logic [REG_AW-1:0]   w_rb;

    assign w_op = opcode_e'(i_instr[11:9]);
    assign w_rd = i_instr[8:6];
    assign w_ra = i_instr[5:3];
    assign w_rb = i_instr[2:0];

    always_comb begin
        o_rf_we      = 1'b0;
        o_dmem_we    = 1'b0;
        o_wb_sel     = 1'b0;
        o_alu_select = 1'b0;
        o_rf_wa      = '0;
        o_rf_ra      = '0;
        o_rf_rb      = '0;
        o_is_bnz     = 1'b0;
        o_is_jmp     = 1'b0;
        o_is_halt    = 1'b0;
        case (w_op)
            OP_LOAD: begin
                o_rf_we  = 1'b1;
                o_rf_wa  = w_rd;
                o_wb_sel = 1'b1;
            end
            OP_STORE: begin
                o_dmem_we = 1'b1;
                o_rf_ra   = w_rd;
            end
            OP_ADD, OP_CMP: begin
                o_rf_we      = 1'b1;
                o_rf_wa      = w_rd;
                o_rf_ra      = w_ra;
                o_rf_rb      = w_rb;
                o_alu_select = (w_op == OP_CMP);
            end
            OP_BNZ: begin
                o_is_bnz = 1'b1;
                o_rf_ra  = w_rd;
            end
            OP_JMP:  o_is_jmp  = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_controller.sv
// Two-cycle FETCH/EXEC controller: owns the FSM, program counter and retired-instruction counter.
module instruction_controller
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [REG_AW-1:0]  rf_ra,
    output logic [REG_AW-1:0]  rf_rb,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_wa,
    output logic               wb_sel,
    output logic               alu_select,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_e             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [CNT_W-1:0]   r_count;
    logic               r_halted;

    logic               w_exec;
    logic               w_dec_rf_we;
    logic               w_dec_dmem_we;
    logic               w_dec_wb_sel;
    logic               w_dec_alu_select;
    logic [REG_AW-1:0]  w_dec_rf_wa;
    logic [REG_AW-1:0]  w_dec_rf_ra;
    logic [REG_AW-1:0]  w_dec_rf_rb;
    logic               w_dec_is_bnz;
    logic               w_dec_is_jmp;
    logic               w_dec_is_halt;
    logic               w_take;
    logic [PC_W-1:0]    w_pc_next;

    instr_decoder u_decoder (
        .i_instr      (imem_data),
        .o_rf_we      (w_dec_rf_we),
        .o_dmem_we    (w_dec_dmem_we),
        .o_wb_sel     (w_dec_wb_sel),
        .o_alu_select (w_dec_alu_select),
        .o_rf_wa      (w_dec_rf_wa),
        .o_rf_ra      (w_dec_rf_ra),
        .o_rf_rb      (w_dec_rf_rb),
        .o_is_bnz     (w_dec_is_bnz),
        .o_is_jmp     (w_dec_is_jmp),
        .o_is_halt    (w_dec_is_halt)
    );

    assign w_exec = (r_state == ST_EXEC);

    // imem_data is only meaningful in EXEC, so every decoded control is gated by it
    assign rf_we      = w_exec & w_dec_rf_we;
    assign dmem_we    = w_exec & w_dec_dmem_we;
    assign wb_sel     = w_exec & w_dec_wb_sel;
    assign alu_select = w_exec & w_dec_alu_select;
    assign rf_wa      = w_exec ? w_dec_rf_wa : '0;
    assign rf_ra      = w_exec ? w_dec_rf_ra : '0;
    assign rf_rb      = w_exec ? w_dec_rf_rb : '0;
    assign dmem_addr  = w_exec ? imem_data[DMEM_AW-1:0] : '0;

    assign w_take    = w_dec_is_jmp | (w_dec_is_bnz & (rf_rdata_a != '0));
    assign w_pc_next = w_take ? imem_data[PC_W-1:0] : r_pc + PC_W'(1);

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign instr_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run || step) r_state <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_count <= sat_inc(r_count);
                    if (w_dec_is_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_state <= run ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller with an EXEC-cycle scoreboard.
module tb_instruction_controller;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic [4:0]  imem_addr;
    logic [11:0] imem_data;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic [7:0]  rf_rdata_a;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic        wb_sel;
    logic        alu_select;
    logic        dmem_we;
    logic [5:0]  dmem_addr;
    logic [4:0]  pc;
    logic        halted;
    logic [7:0]  instr_count;

    logic [11:0] imem [32];

    typedef struct packed {
        logic       rf_we;
        logic       dmem_we;
        logic [2:0] rf_wa;
        logic [2:0] rf_ra;
        logic [2:0] rf_rb;
        logic       alu;
        logic       wb;
        logic [4:0] pc_after;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instruction_controller dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_rdata_a  (rf_rdata_a),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .wb_sel      (wb_sel),
        .alu_select  (alu_select),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle of read latency
    always @(posedge clk) imem_data <= imem[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [5:0] low);
        return {op, rd, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_opt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        if (!$isunknown(exp)) chk(tag, obs, exp);
    endtask

    task automatic push(input logic we, input logic dwe, input logic [2:0] wa,
                        input logic [2:0] ra, input logic [2:0] rb, input logic alu,
                        input logic wb, input logic [4:0] pc_after);
        exp_t e;
        e.rf_we = we;  e.dmem_we = dwe; e.rf_wa = wa; e.rf_ra = ra;
        e.rf_rb = rb;  e.alu = alu;     e.wb = wb;    e.pc_after = pc_after;
        sb.push_back(e);
    endtask

    task automatic check_exec(input string tag, output exp_t e);
        e = '0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rf_we"},   8'(rf_we),      8'(e.rf_we));
            chk({tag, ".dmem_we"}, 8'(dmem_we),    8'(e.dmem_we));
            chk_opt({tag, ".rf_wa"}, 8'(rf_wa),    8'(e.rf_wa));
            chk_opt({tag, ".rf_ra"}, 8'(rf_ra),    8'(e.rf_ra));
            chk_opt({tag, ".rf_rb"}, 8'(rf_rb),    8'(e.rf_rb));
            chk_opt({tag, ".alu"},   8'(alu_select), 8'(e.alu));
            chk_opt({tag, ".wb"},    8'(wb_sel),   8'(e.wb));
        end
    endtask

    // One stepped instruction: FETCH, EXEC (scoreboard), then the PC after EXEC
    task automatic run_one(input string tag, input logic [7:0] rdata);
        exp_t e;
        rf_rdata_a = rdata;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk({tag, ".fetch_en"}, 8'(rf_we | dmem_we), 8'd0);
        tick();
        check_exec(tag, e);
        tick();
        chk({tag, ".pc"}, 8'(pc), 8'(e.pc_after));
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; run = 1'b0; step = 1'b0; rf_rdata_a = 8'd0;
        for (int i = 0; i < 32; i++) imem[i] = enc(3'b110, 3'd0, 6'd0);
        imem[0]  = enc(3'b010, 3'd1, {3'd2, 3'd3});   // ADD r1,r2,r3
        imem[1]  = enc(3'b011, 3'd4, {3'd1, 3'd2});   // CMP r4,r1,r2
        imem[2]  = enc(3'b100, 3'd5, 6'd20);          // BNZ r5,20
        imem[3]  = enc(3'b100, 3'd5, 6'd20);          // BNZ r5,20
        imem[20] = enc(3'b101, 3'd0, 6'd31);          // JMP 31
        tick();
        tick();
        chk("rst.pc", 8'(pc), 8'd0);
        chk("rst.count", instr_count, 8'd0);
        chk("rst.halted", 8'(halted), 8'd0);
        chk("rst.en", 8'(rf_we | dmem_we | wb_sel | alu_select), 8'd0);

        // ADD under run; run drops during FETCH so the controller settles in IDLE
        push(1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 5'd1);
        reset = 1'b0; run = 1'b1;
        tick();
        chk("add.fetch_addr", 8'(imem_addr), 8'd0);
        chk("add.fetch_en", 8'(rf_we | dmem_we), 8'd0);
        run = 1'b0;
        tick();
        check_exec("add", e);
        tick();
        chk("add.pc", 8'(pc), 8'(e.pc_after));
        chk("add.count", instr_count, 8'd1);
        tick();
        tick();
        chk("add.idle_count", instr_count, 8'd1);

        // CMP by step; a second step during EXEC must be dropped
        push(1'b1, 1'b0, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 5'd2);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("cmp.fetch_en", 8'(rf_we | dmem_we), 8'd0);
        tick();
        check_exec("cmp", e);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("cmp.pc", 8'(pc), 8'(e.pc_after));
        chk("cmp.count", instr_count, 8'd2);
        tick(); tick(); tick();
        chk("cmp.step_ignored", instr_count, 8'd2);

        push(1'b0, 1'b0, 3'bx, 3'd5, 3'bx, 1'bx, 1'bx, 5'd3);
        run_one("bnz_nt", 8'h00);
        push(1'b0, 1'b0, 3'bx, 3'd5, 3'bx, 1'bx, 1'bx, 5'd20);
        run_one("bnz_t", 8'h07);
        push(1'b0, 1'b0, 3'bx, 3'bx, 3'bx, 1'bx, 1'bx, 5'd31);
        run_one("jmp", 8'h00);
        push(1'b0, 1'b0, 3'bx, 3'bx, 3'bx, 1'bx, 1'bx, 5'd0);
        run_one("nop_wrap", 8'h00);
        chk("pre_halt.halted", 8'(halted), 8'd0);

        imem[0] = enc(3'b111, 3'd0, 6'd0);
        push(1'b0, 1'b0, 3'bx, 3'bx, 3'bx, 1'bx, 1'bx, 5'd0);
        run_one("halt", 8'h00);
        chk("halt.halted", 8'(halted), 8'd1);
        chk("halt.count", instr_count, 8'd7);
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();
        run = 1'b0;
        chk("halt.stuck_pc", 8'(pc), 8'd0);
        chk("halt.stuck_count", instr_count, 8'd7);
        chk("halt.stuck_halted", 8'(halted), 8'd1);
        chk("halt.stuck_en", 8'(rf_we | dmem_we), 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_rst.halted", 8'(halted), 8'd0);
        chk("halt_rst.pc", 8'(pc), 8'd0);
        chk("halt_rst.count", instr_count, 8'd0);

        // STORE interrupted by reset in its EXEC cycle
        imem[0] = enc(3'b001, 3'd2, 6'h2A);
        push(1'b0, 1'b1, 3'bx, 3'd2, 3'bx, 1'bx, 1'bx, 5'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check_exec("store", e);
        chk("store.dmem_addr", 8'(dmem_addr), 8'h2A);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("store_rst.dmem_we", 8'(dmem_we), 8'd0);
        chk("store_rst.pc", 8'(pc), 8'd0);
        chk("store_rst.count", instr_count, 8'd0);
        tick();
        chk("store_rst.idle_we", 8'(dmem_we), 8'd0);
        push(1'b0, 1'b1, 3'bx, 3'd2, 3'bx, 1'bx, 1'bx, 5'd1);
        run_one("store2", 8'h00);

        imem[1] = enc(3'b000, 3'd6, 6'd0);
        push(1'b1, 1'b0, 3'd6, 3'bx, 3'bx, 1'bx, 1'b1, 5'd2);
        run_one("load", 8'h00);

        // Long NOP run to drive the retired counter into saturation
        reset = 1'b1;
        for (int i = 0; i < 32; i++) imem[i] = enc(3'b110, 3'd0, 6'd0);
        tick();
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 540; i++) tick();
        run = 1'b0;
        tick(); tick();
        chk("sat.count", instr_count, 8'd255);
        chk("sb.drained", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
